// File: rtl/rate_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// rate_pattern_gen_if
//
// Bus between the master FSM and the rate/pattern generator.
//
// Signals
//   state          master -> gen  3-bit pattern mode
//   shift_left_1   master -> gen  slow-down request, period x2
//   shift_left_2   master -> gen  slow-down request, period x4
//   shift_right_1  master -> gen  speed-up request, period /2
//   shift_right_2  master -> gen  speed-up request, period /4
//   period         gen -> master  current tick period in clock cycles
//   tick           gen -> master  one-cycle strobe per elapsed period
//   led            gen -> master  8-bit pattern
//   at_min/at_max  gen -> master  period saturation flags
//                                 (only when RATE_LIMIT_FLAGS_EN is defined)
//
// Modports: master (drives mode and shift requests), slave (the generator).
// ---------------------------------------------------------------------------
interface rate_pattern_gen_if #(
    parameter int PERIOD_W = 8
);
    logic [2:0]          state;
    logic                shift_left_1;
    logic                shift_left_2;
    logic                shift_right_1;
    logic                shift_right_2;
    logic [PERIOD_W-1:0] period;
    logic                tick;
    logic [7:0]          led;
`ifdef RATE_LIMIT_FLAGS_EN
    logic                at_min;
    logic                at_max;

    modport master (
        output state, shift_left_1, shift_left_2, shift_right_1, shift_right_2,
        input  period, tick, led, at_min, at_max
    );

    modport slave (
        input  state, shift_left_1, shift_left_2, shift_right_1, shift_right_2,
        output period, tick, led, at_min, at_max
    );
`else
    modport master (
        output state, shift_left_1, shift_left_2, shift_right_1, shift_right_2,
        input  period, tick, led
    );

    modport slave (
        input  state, shift_left_1, shift_left_2, shift_right_1, shift_right_2,
        output period, tick, led
    );
`endif
endinterface

// File: rtl/rate_pattern_gen.sv
// ---------------------------------------------------------------------------
// rate_pattern_gen
//
// Programmable-rate tick generator driving an 8-bit LED pattern. The tick
// period is doubled/quadrupled or halved/quartered by level-sampled shift
// requests and saturates at MIN_PERIOD/MAX_PERIOD. Each elapsed period emits
// a one-cycle tick and advances the LED pattern selected by 'state'. A change
// of 'state' loads that mode's seed pattern immediately.
//
// Ports
//   clock   sole clock, rising edge
//   reset   synchronous, active-high
//   bus     rate_pattern_gen_if.slave (mode/shift inputs, period/tick/led out)
//
// Build option
//   RATE_LIMIT_FLAGS_EN  when defined, drives bus.at_min / bus.at_max
//                        (period at MIN_PERIOD / MAX_PERIOD).
// ---------------------------------------------------------------------------
module rate_pattern_gen #(
    parameter int PERIOD_W    = 8,
    parameter int INIT_PERIOD = 16,
    parameter int MIN_PERIOD  = 1,
    parameter int MAX_PERIOD  = 128
) (
    input  logic              clock,
    input  logic              reset,
    rate_pattern_gen_if.slave bus
);

    localparam int WIDE_W = PERIOD_W + 2;
    localparam logic [PERIOD_W-1:0] INIT_P = PERIOD_W'(INIT_PERIOD);
    localparam logic [PERIOD_W-1:0] MIN_P  = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] MAX_P  = PERIOD_W'(MAX_PERIOD);
    localparam logic [WIDE_W-1:0]   MAX_W  = WIDE_W'(MAX_PERIOD);

    typedef enum logic [2:0] {
        MODE_OFF = 3'd0,
        MODE_ROL = 3'd1,
        MODE_ROR = 3'd2,
        MODE_INV = 3'd3,
        MODE_CNT = 3'd4
    } mode_e;

    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] count_q;
    logic                tick_q;
    logic [7:0]          led_q;
    logic [2:0]          prev_state_q;

    logic [PERIOD_W-1:0] period_next;
    logic [WIDE_W-1:0]   left_wide;
    logic [PERIOD_W-1:0] right_shifted;
    logic [1:0]          shift_amt;
    logic                any_left;
    logic                any_right;
    logic                period_change;
    logic                wrap;
    logic                state_change;

    // Seed pattern loaded whenever the mode changes.
    function automatic logic [7:0] seed_of(input logic [2:0] mode);
        case (mode_e'(mode))
            MODE_ROL: seed_of = 8'h01;
            MODE_ROR: seed_of = 8'h80;
            MODE_INV: seed_of = 8'hAA;
            default:  seed_of = 8'h00;
        endcase
    endfunction

    // One pattern step, applied on each elapsed period.
    function automatic logic [7:0] step_of(input logic [2:0] mode, input logic [7:0] cur);
        case (mode_e'(mode))
            MODE_ROL: step_of = {cur[6:0], cur[7]};
            MODE_ROR: step_of = {cur[0], cur[7:1]};
            MODE_INV: step_of = ~cur;
            MODE_CNT: step_of = cur + 8'd1;
            default:  step_of = 8'h00;
        endcase
    endfunction

    // Request resolution: opposing directions cancel, _2 beats _1. Left shifts
    // are evaluated two bits wider so the saturation compare sees the true value.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        any_left      = bus.shift_left_1 | bus.shift_left_2;
        any_right     = bus.shift_right_1 | bus.shift_right_2;
        period_next   = period_q;
        left_wide     = '0;
        right_shifted = '0;
        shift_amt     = 2'd1;
        if (any_left && !any_right) begin
            shift_amt = bus.shift_left_2 ? 2'd2 : 2'd1;
            left_wide = {2'b00, period_q} << shift_amt;
            period_next = (left_wide > MAX_W) ? MAX_P : left_wide[PERIOD_W-1:0];
        end else if (any_right && !any_left) begin
            shift_amt     = bus.shift_right_2 ? 2'd2 : 2'd1;
            right_shifted = period_q >> shift_amt;
            period_next   = (right_shifted < MIN_P) ? MIN_P : right_shifted;
        end
    end

    // A saturated request leaves period unchanged and must not disturb the count.
    assign period_change = (period_next != period_q);
    assign wrap          = (count_q == period_q - PERIOD_W'(1));
    assign state_change  = (bus.state != prev_state_q);

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            period_q     <= INIT_P;
            count_q      <= '0;
            tick_q       <= 1'b0;
            led_q        <= 8'h00;
            prev_state_q <= 3'd0;
        end else begin
            prev_state_q <= bus.state;

            // A period change restarts the count and suppresses this edge's tick.
            if (period_change) begin
                period_q <= period_next;
                count_q  <= '0;
                tick_q   <= 1'b0;
            end else if (wrap) begin
                count_q <= '0;
                tick_q  <= 1'b1;
            end else begin
                count_q <= count_q + PERIOD_W'(1);
                tick_q  <= 1'b0;
            end

            // Seed load on a mode change takes priority over a pattern step.
            if (state_change) begin
                led_q <= seed_of(bus.state);
            end else if (wrap && !period_change) begin
                led_q <= step_of(bus.state, led_q);
            end
        end
    end

    assign bus.period = period_q;
    assign bus.tick   = tick_q;
    assign bus.led    = led_q;

`ifdef RATE_LIMIT_FLAGS_EN
    assign bus.at_min = (period_q == MIN_P);
    assign bus.at_max = (period_q == MAX_P);
`endif

endmodule

// File: tb/tb_rate_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_rate_pattern_gen
//
// Directed bench for rate_pattern_gen. The stimulus process drives the bus
// on falling edges and pushes each expected tick (edge index, led, period)
// into a queue; a separate monitor pops and compares on every tick seen.
// Edges are numbered from 1 (first rising edge of the clock).
// ---------------------------------------------------------------------------
module tb_rate_pattern_gen;

    localparam int PERIOD_W = 8;

    typedef struct {
        int        edge_idx;
        logic [7:0] led;
        logic [7:0] period;
    } tick_exp_t;

    logic clock = 1'b0;
    logic reset;
    int   edge_n = 0;
    int   checks = 0;
    int   failures = 0;
    tick_exp_t exp_q[$];

    rate_pattern_gen_if #(.PERIOD_W(PERIOD_W)) bus ();

    rate_pattern_gen #(
        .PERIOD_W   (PERIOD_W),
        .INIT_PERIOD(16),
        .MIN_PERIOD (1),
        .MAX_PERIOD (128)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", name, edge_n, actual, expected);
        end
    endtask

    task automatic push_tick(input int e, input logic [7:0] l, input logic [7:0] p);
        tick_exp_t t;
        t.edge_idx = e;
        t.led      = l;
        t.period   = p;
        exp_q.push_back(t);
    endtask

    // Returns at the falling edge that follows rising edge 'target'.
    task automatic wait_until(input int target);
        while (edge_n < target) @(negedge clock);
    endtask

    task automatic set_shifts(input logic l1, input logic l2, input logic r1, input logic r2);
        bus.shift_left_1  = l1;
        bus.shift_left_2  = l2;
        bus.shift_right_1 = r1;
        bus.shift_right_2 = r2;
    endtask

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (bus.tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tick: tick at edge %0d, none expected", edge_n);
            end else begin
                tick_exp_t e;
                e = exp_q.pop_front();
                check("tick_edge", edge_n, e.edge_idx);
                check("tick_led", {24'd0, bus.led}, {24'd0, e.led});
                check("tick_period", {24'd0, bus.period}, {24'd0, e.period});
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        bus.state = 3'd0;
        set_shifts(0, 0, 0, 0);

        // Reset for two edges, state 0: ticks every 16, led held at 0.
        wait_until(2);
        reset = 1'b0;
        check("reset_period", {24'd0, bus.period}, 32'd16);
        check("reset_tick", {31'd0, bus.tick}, 32'd0);
        check("reset_led", {24'd0, bus.led}, 32'h00);
        push_tick(18, 8'h00, 8'd16);
        push_tick(34, 8'h00, 8'd16);
        wait_until(34);

        // Rotate left from seed 0x01, one step per 16-cycle tick.
        bus.state = 3'd1;
        for (int k = 1; k <= 8; k++) begin
            logic [7:0] one;
            one = 8'h01;
            push_tick(34 + 16 * k, one << (k % 8), 8'd16);
        end
        wait_until(35);
        check("rol_seed", {24'd0, bus.led}, 32'h01);
        wait_until(162);

        // shift_right_1: 16 -> 8, no tick on the changing edge.
        set_shifts(0, 0, 1, 0);
        push_tick(171, 8'h02, 8'd8);
        push_tick(179, 8'h04, 8'd8);
        wait_until(163);
        set_shifts(0, 0, 0, 0);
        check("sr1_period", {24'd0, bus.period}, 32'd8);
        check("sr1_no_tick", {31'd0, bus.tick}, 32'd0);
        wait_until(179);

        // shift_right_2 twice: 8 -> 2 -> 1 (saturated), tick every edge.
        set_shifts(0, 0, 0, 1);
        push_tick(182, 8'h08, 8'd1);
        push_tick(183, 8'h10, 8'd1);
        push_tick(184, 8'h20, 8'd1);
        push_tick(185, 8'h40, 8'd1);
        push_tick(186, 8'h80, 8'd1);
        push_tick(187, 8'h01, 8'd1);
        push_tick(188, 8'h02, 8'd1);
        push_tick(189, 8'h04, 8'd1);
        wait_until(180);
        check("sr2_period_2", {24'd0, bus.period}, 32'd2);
        wait_until(181);
        set_shifts(0, 0, 0, 0);
        check("sr2_period_1", {24'd0, bus.period}, 32'd1);
`ifdef RATE_LIMIT_FLAGS_EN
        check("at_min_at_1", {31'd0, bus.at_min}, 32'd1);
        check("at_max_at_1", {31'd0, bus.at_max}, 32'd0);
`endif
        wait_until(189);

        // shift_left_2 x4: 1 -> 4 -> 16 -> 64 -> 128 (saturated).
        set_shifts(0, 1, 0, 0);
        wait_until(190);
        check("sl2_period_4", {24'd0, bus.period}, 32'd4);
        wait_until(191);
        check("sl2_period_16", {24'd0, bus.period}, 32'd16);
        wait_until(192);
        check("sl2_period_64", {24'd0, bus.period}, 32'd64);
        wait_until(193);
        set_shifts(0, 0, 0, 0);
        check("sl2_period_128", {24'd0, bus.period}, 32'd128);
        // Count restarted at edge 193; saturated and cancelled requests below
        // must not restart it, so the tick lands at 193 + 128.
        push_tick(321, 8'h08, 8'd128);
        wait_until(199);
        set_shifts(1, 0, 0, 0);
        wait_until(200);
        check("sl1_saturated", {24'd0, bus.period}, 32'd128);
`ifdef RATE_LIMIT_FLAGS_EN
        check("at_max_at_128", {31'd0, bus.at_max}, 32'd1);
        check("at_min_at_128", {31'd0, bus.at_min}, 32'd0);
`endif
        set_shifts(1, 0, 0, 1);
        wait_until(201);
        set_shifts(0, 0, 0, 0);
        check("opposing_cancel", {24'd0, bus.period}, 32'd128);
        wait_until(321);

        // 128 -> 32 -> 8, then mode 2 then mode 4 mid-period.
        set_shifts(0, 0, 0, 1);
        wait_until(323);
        set_shifts(0, 0, 0, 0);
        check("sr2_period_8", {24'd0, bus.period}, 32'd8);
        bus.state = 3'd2;
        push_tick(331, 8'h40, 8'd8);
        push_tick(339, 8'h01, 8'd8);
        push_tick(347, 8'h02, 8'd8);
        wait_until(324);
        check("ror_seed", {24'd0, bus.led}, 32'h80);
        wait_until(333);
        bus.state = 3'd4;
        wait_until(334);
        check("cnt_seed", {24'd0, bus.led}, 32'h00);
        wait_until(347);

        // Period 4 with mode 3 (invert).
        set_shifts(0, 0, 1, 0);
        bus.state = 3'd3;
        push_tick(352, 8'h55, 8'd4);
        push_tick(356, 8'hAA, 8'd4);
        wait_until(348);
        set_shifts(0, 0, 0, 0);
        check("p4_period", {24'd0, bus.period}, 32'd4);
        check("inv_seed", {24'd0, bus.led}, 32'hAA);
        wait_until(357);

        // Reset mid-period with a simultaneous shift request.
        reset = 1'b1;
        set_shifts(1, 0, 0, 0);
        wait_until(358);
        reset = 1'b0;
        set_shifts(0, 0, 0, 0);
        check("rst2_period", {24'd0, bus.period}, 32'd16);
        check("rst2_led", {24'd0, bus.led}, 32'h00);
        check("rst2_tick", {31'd0, bus.tick}, 32'd0);
        push_tick(374, 8'h55, 8'd16);
        wait_until(359);
        check("rst2_seed", {24'd0, bus.led}, 32'hAA);
        wait_until(376);

        // Mode 4 at period 1: full 0x00..0xFF count and wrap to 0x00.
        set_shifts(0, 0, 0, 1);
        bus.state = 3'd4;
        for (int k = 1; k <= 256; k++) push_tick(378 + k, 8'(k), 8'd1);
        wait_until(377);
        check("cnt_p4", {24'd0, bus.period}, 32'd4);
        check("cnt_seed2", {24'd0, bus.led}, 32'h00);
        wait_until(378);
        set_shifts(0, 0, 0, 0);
        check("cnt_p1", {24'd0, bus.period}, 32'd1);
        wait_until(634);

        // Back up to the ceiling; no further ticks in the remaining window.
        set_shifts(0, 1, 0, 0);
        wait_until(637);
        check("final_p64", {24'd0, bus.period}, 32'd64);
        wait_until(638);
        set_shifts(0, 0, 0, 0);
        check("final_p128", {24'd0, bus.period}, 32'd128);
        wait_until(642);

        check("tick_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rate_pattern_gen.md
RATE_PATTERN_GEN -- requirements
Module: rate_pattern_gen

Interface
REQ-001 Parameter: PERIOD_W, 8, width of the tick-period register and counter.
REQ-002 Parameter: INIT_PERIOD, 16, period loaded at reset (power of two, MIN_PERIOD..MAX_PERIOD).
REQ-003 Parameter: MIN_PERIOD, 1, lower saturation bound of period.
REQ-004 Parameter: MAX_PERIOD, 128, upper saturation bound of period (power of two, < 2^PERIOD_W).
REQ-005 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: state  input  3  pattern mode from master FSM.
REQ-008 Port: shift_left_1 / shift_left_2  input  1 each  slow-down requests: period x2 / x4.
REQ-009 Port: shift_right_1 / shift_right_2  input  1 each  speed-up requests: period /2 / /4.
REQ-010 Port: period  output  PERIOD_W  current tick period in clock cycles.
REQ-011 Port: tick  output  1  registered one-cycle strobe per elapsed period.
REQ-012 Port: led  output  8  registered pattern output.

Function
REQ-013 Shift inputs are level-sampled every edge; each cycle high is one request.
REQ-014 Request resolution per edge: any left AND any right -> no change; else _2 overrides _1 in same direction; none -> no change.
REQ-015 Left shift: period <= min(period << n, MAX_PERIOD); right shift: period <= max(period >> n, MIN_PERIOD); n = 1 or 2; no wrap, no zero.
REQ-016 Latency: request sampled at edge N; new period visible after edge N.
REQ-017 Counter counts 0..period-1; at count == period-1 it wraps to 0, tick <= 1 and led advances, all on the same edge; otherwise tick <= 0.
REQ-018 An edge that changes period clears counter to 0 and forces tick <= 0 and no led advance; a saturated (unchanged) request does not clear the counter.
REQ-019 period == 1: tick high every cycle, led advances every cycle.
REQ-020 Pattern by state on advance: 0 led=0x00 hold; 1 rotate left; 2 rotate right; 3 led <= ~led; 4 led <= led+1 (wraps 0xFF->0x00); 5-7 led=0x00 hold.
REQ-021 state change (differs from previous-cycle value) loads seed on that edge, overriding advance: 1 -> 0x01, 2 -> 0x80, 3 -> 0xAA, 4 -> 0x00, else 0x00; counter and period unaffected.
REQ-022 Rotations wrap: 0x80 rotate left -> 0x01; 0x01 rotate right -> 0x80.

Reset
REQ-023 On reset edge: period = INIT_PERIOD, counter = 0, tick = 0, led = 0x00, stored previous state = 0.
REQ-024 Reset overrides all simultaneous shift requests and state changes; reset mid-period discards partial count.
REQ-025 First edge after reset release with state != 0 is a state change and loads that seed.

Configuration
REQ-026 Macro RATE_LIMIT_FLAGS_EN defined: adds outputs at_min (1 bit, period == MIN_PERIOD) and at_max (1 bit, period == MAX_PERIOD), derived combinationally from period register.
REQ-027 Macro RATE_LIMIT_FLAGS_EN undefined: ports at_min/at_max absent; all other behaviour identical.

Verification
REQ-028 Reset asserted 2 cycles then released, state=0 -> period=16, tick=0, led=0x00; tick pulses every 16 cycles, led stays 0x00.
REQ-029 state=1, no shifts -> led 0x01 after first edge, then 0x02,0x04,...,0x80,0x01, one step per tick, ticks spaced 16 cycles.
REQ-030 shift_right_1 one cycle at period 16 -> period=8 next cycle, no tick that edge, subsequent ticks every 8 cycles; then shift_right_2 twice -> 2, then 1 (saturated), tick continuously high.
REQ-031 shift_left_2 at period 64 -> 128 (saturated); shift_left_1 at 128 -> stays 128, counter not cleared; shift_left_1 with shift_right_2 same cycle -> unchanged.
REQ-032 state 2 -> 4 mid-period -> led 0x00 loaded immediately, increments 0x01, 0x02 on following ticks, tick spacing unchanged.
REQ-033 Reset pulsed mid-period at period 4, state=3 -> period=16, led=0x00, tick=0; next edge loads 0xAA, first tick 16 cycles later gives 0x55; with RATE_LIMIT_FLAGS_EN, at_min=1 at period 1, at_max=1 at 128.
